// File: rtl/matrix_mem_banked_pkg.sv
// matrix_mem_pkg: shared FSM type and sizing/init helpers for the banked matrix memory
package matrix_mem_pkg;
    typedef enum logic {INIT, IDLE} state_t;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    function automatic int init_val(input int i, input int j, input int base, input int row_step, input int col_step);
        return base + row_step * i + col_step * j;
    endfunction
endpackage

// File: rtl/matrix_mem_banked_if.sv
// matrix_mem_if: control, write and dual read port bundle for the matrix memory
interface matrix_mem_if import matrix_mem_pkg::*; #(
    parameter int ROWS  = 2,
    parameter int COLS  = 2,
    parameter int WIDTH = 8
);
    localparam int RW = idx_w(ROWS);
    localparam int CW = idx_w(COLS);
    logic             init_req;
    logic             busy;
    logic             wr_en;
    logic [RW-1:0]    wr_row;
    logic [CW-1:0]    wr_col;
    logic [WIDTH-1:0] wr_data;
    logic             wr_ack;
    logic             rd_a_en;
    logic [RW-1:0]    rd_a_row;
    logic [CW-1:0]    rd_a_col;
    logic [WIDTH-1:0] rd_a_data;
    logic             rd_a_valid;
    logic             rd_b_en;
    logic [RW-1:0]    rd_b_row;
    logic [CW-1:0]    rd_b_col;
    logic             rd_b_trans;
    logic [WIDTH-1:0] rd_b_data;
    logic             rd_b_valid;
    logic             addr_err;
    modport master (
        output init_req, wr_en, wr_row, wr_col, wr_data,
        output rd_a_en, rd_a_row, rd_a_col, rd_b_en, rd_b_row, rd_b_col, rd_b_trans,
        input  busy, wr_ack, rd_a_data, rd_a_valid, rd_b_data, rd_b_valid, addr_err
    );
    modport slave (
        input  init_req, wr_en, wr_row, wr_col, wr_data,
        input  rd_a_en, rd_a_row, rd_a_col, rd_b_en, rd_b_row, rd_b_col, rd_b_trans,
        output busy, wr_ack, rd_a_data, rd_a_valid, rd_b_data, rd_b_valid, addr_err
    );
endinterface

// File: rtl/matrix_mem_banked_init_seq.sv
// matrix_mem_init_seq: one-element-per-cycle init sweep FSM driving the array write port
module matrix_mem_init_seq import matrix_mem_pkg::*; #(
    parameter int ROWS      = 2,
    parameter int COLS      = 2,
    parameter int WIDTH     = 8,
    parameter int INIT_BASE = 5,
    parameter int ROW_STEP  = 2,
    parameter int COL_STEP  = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            init_req,
    output logic                            busy,
    output logic                            sw_en,
    output logic [idx_w(ROWS*COLS)-1:0]     sw_idx,
    output logic [WIDTH-1:0]                sw_data
);
    localparam int RW = idx_w(ROWS);
    localparam int CW = idx_w(COLS);
    localparam int AW = idx_w(ROWS*COLS);
    state_t        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          col_end, last;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end
    // counters rest at zero in IDLE, so a new sweep always starts at element 0
    always_comb begin
        col_end = int'(col_q) == COLS - 1;
        last    = col_end && int'(row_q) == ROWS - 1;
        state_d = (state_q == IDLE) ? (init_req ? INIT : IDLE) : (last ? IDLE : INIT);
        col_d   = (state_q == IDLE || col_end) ? '0 : col_q + CW'(1);
        row_d   = (state_q == IDLE || last) ? '0 : (col_end ? row_q + RW'(1) : row_q);
    end
    always_comb begin
        busy    = state_q == INIT;
        sw_en   = busy;
        sw_idx  = AW'(int'(row_q) * COLS + int'(col_q));
        sw_data = WIDTH'(init_val(int'(row_q), int'(col_q), INIT_BASE, ROW_STEP, COL_STEP));
    end
endmodule

// File: rtl/matrix_mem_banked.sv
// matrix_mem_banked: ROWSxCOLS element store with acked write, two registered reads and transposed port B
module matrix_mem_banked import matrix_mem_pkg::*; #(
    parameter int ROWS      = 2,
    parameter int COLS      = 2,
    parameter int WIDTH     = 8,
    parameter int INIT_BASE = 5,
    parameter int ROW_STEP  = 2,
    parameter int COL_STEP  = 1
) (
    input logic        clk,
    input logic        rst,
    matrix_mem_if.slave bus
);
    localparam int N  = ROWS * COLS;
    localparam int AW = idx_w(N);
    logic [WIDTH-1:0] mem [N];
    logic             busy, sw_en;
    logic [AW-1:0]    sw_idx, w_idx, a_idx, b_idx;
    logic [WIDTH-1:0] sw_data;
    int               b_row, b_col;
    logic             w_ok, a_ok, b_ok, w_go, a_go, b_go;
    logic             wr_ack_q, wr_ack_d, addr_err_q, addr_err_d;
    logic             rd_a_valid_q, rd_a_valid_d, rd_b_valid_q, rd_b_valid_d;
    logic [WIDTH-1:0] rd_a_data_q, rd_a_data_d, rd_b_data_q, rd_b_data_d;
    matrix_mem_init_seq #(
        .ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH),
        .INIT_BASE(INIT_BASE), .ROW_STEP(ROW_STEP), .COL_STEP(COL_STEP)
    ) u_init_seq (
        .clk(clk), .rst(rst), .init_req(bus.init_req), .busy(busy),
        .sw_en(sw_en), .sw_idx(sw_idx), .sw_data(sw_data)
    );
    // port B swaps row/col before the range check, so non-square transposes can fall outside
    always_comb begin
        b_row        = bus.rd_b_trans ? int'(bus.rd_b_col) : int'(bus.rd_b_row);
        b_col        = bus.rd_b_trans ? int'(bus.rd_b_row) : int'(bus.rd_b_col);
        w_ok         = int'(bus.wr_row) < ROWS && int'(bus.wr_col) < COLS;
        a_ok         = int'(bus.rd_a_row) < ROWS && int'(bus.rd_a_col) < COLS;
        b_ok         = b_row < ROWS && b_col < COLS;
        w_idx        = AW'(int'(bus.wr_row) * COLS + int'(bus.wr_col));
        a_idx        = AW'(int'(bus.rd_a_row) * COLS + int'(bus.rd_a_col));
        b_idx        = AW'(b_row * COLS + b_col);
        w_go         = !busy && bus.wr_en && w_ok;
        a_go         = !busy && bus.rd_a_en;
        b_go         = !busy && bus.rd_b_en;
        wr_ack_d     = w_go;
        addr_err_d   = !busy && ((bus.wr_en && !w_ok) || (bus.rd_a_en && !a_ok) || (bus.rd_b_en && !b_ok));
        rd_a_valid_d = a_go;
        rd_b_valid_d = b_go;
        rd_a_data_d  = a_go ? (a_ok ? mem[a_idx] : '0) : rd_a_data_q;
        rd_b_data_d  = b_go ? (b_ok ? mem[b_idx] : '0) : rd_b_data_q;
    end
    always_ff @(posedge clk) begin
        if (sw_en) mem[sw_idx] <= sw_data;
        else if (w_go) mem[w_idx] <= bus.wr_data;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ack_q     <= 1'b0;
            addr_err_q   <= 1'b0;
            rd_a_valid_q <= 1'b0;
            rd_b_valid_q <= 1'b0;
            rd_a_data_q  <= '0;
            rd_b_data_q  <= '0;
        end else begin
            wr_ack_q     <= wr_ack_d;
            addr_err_q   <= addr_err_d;
            rd_a_valid_q <= rd_a_valid_d;
            rd_b_valid_q <= rd_b_valid_d;
            rd_a_data_q  <= rd_a_data_d;
            rd_b_data_q  <= rd_b_data_d;
        end
    end
    assign bus.busy       = busy;
    assign bus.wr_ack     = wr_ack_q;
    assign bus.addr_err   = addr_err_q;
    assign bus.rd_a_valid = rd_a_valid_q;
    assign bus.rd_b_valid = rd_b_valid_q;
    assign bus.rd_a_data  = rd_a_data_q;
    assign bus.rd_b_data  = rd_b_data_q;
endmodule

// File: tb/tb_matrix_mem_banked.sv
// tb_matrix_mem_banked: directed and random stimulus against an array-level reference model (3x2, wrapping init)
module tb_matrix_mem_banked;
    localparam int R    = 3;
    localparam int C    = 2;
    localparam int W    = 8;
    localparam int BASE = 250;
    localparam int RS   = 3;
    localparam int CS   = 1;
    localparam int N    = R * C;
    localparam int RW   = matrix_mem_pkg::idx_w(R);
    localparam int CW   = matrix_mem_pkg::idx_w(C);
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    matrix_mem_if #(.ROWS(R), .COLS(C), .WIDTH(W)) bus ();
    matrix_mem_banked #(
        .ROWS(R), .COLS(C), .WIDTH(W), .INIT_BASE(BASE), .ROW_STEP(RS), .COL_STEP(CS)
    ) dut (.clk(clk), .rst(rst), .bus(bus));
    int model [N];
    int busy_left;
    int checks = 0;
    int errors = 0;
    logic [W-1:0] e_ad, e_bd;
    logic e_av, e_bv, e_ack, e_err;
    function automatic int init_at(input int k);
        return (BASE + RS * (k / C) + CS * (k % C)) % (1 << W);
    endfunction
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic load_init();
        for (int k = 0; k < N; k++) model[k] = init_at(k);
    endtask
    task automatic set_wr(input int en, input int row, input int col, input int data);
        bus.wr_en   = 1'(en);
        bus.wr_row  = RW'(row);
        bus.wr_col  = CW'(col);
        bus.wr_data = W'(data);
    endtask
    task automatic set_a(input int en, input int row, input int col);
        bus.rd_a_en  = 1'(en);
        bus.rd_a_row = RW'(row);
        bus.rd_a_col = CW'(col);
    endtask
    task automatic set_b(input int en, input int row, input int col, input int trans);
        bus.rd_b_en    = 1'(en);
        bus.rd_b_row   = RW'(row);
        bus.rd_b_col   = CW'(col);
        bus.rd_b_trans = 1'(trans);
    endtask
    task automatic idle_inputs();
        set_wr(0, 0, 0, 0);
        set_a(0, 0, 0);
        set_b(0, 0, 0, 0);
        bus.init_req = 1'b0;
    endtask
    task automatic check_outputs();
        chk("busy", 32'(bus.busy), 32'(busy_left > 0));
        chk("wr_ack", 32'(bus.wr_ack), 32'(e_ack));
        chk("addr_err", 32'(bus.addr_err), 32'(e_err));
        chk("rd_a_valid", 32'(bus.rd_a_valid), 32'(e_av));
        chk("rd_b_valid", 32'(bus.rd_b_valid), 32'(e_bv));
        chk("rd_a_data", 32'(bus.rd_a_data), 32'(e_ad));
        chk("rd_b_data", 32'(bus.rd_b_data), 32'(e_bd));
    endtask
    // one clock: predict from current inputs and model, advance, then compare just after the edge
    task automatic cycle();
        int wr = int'(bus.wr_row), wc = int'(bus.wr_col);
        int ar = int'(bus.rd_a_row), ac = int'(bus.rd_a_col);
        int br = bus.rd_b_trans ? int'(bus.rd_b_col) : int'(bus.rd_b_row);
        int bc = bus.rd_b_trans ? int'(bus.rd_b_row) : int'(bus.rd_b_col);
        bit w_ok = wr < R && wc < C;
        bit a_ok = ar < R && ac < C;
        bit b_ok = br < R && bc < C;
        e_ack = 0; e_av = 0; e_bv = 0; e_err = 0;
        if (busy_left == 0) begin
            if (bus.wr_en) begin
                e_ack = w_ok;
                e_err = !w_ok;
            end
            if (bus.rd_a_en) begin
                e_av = 1;
                e_ad = a_ok ? W'(model[ar * C + ac]) : '0;
                if (!a_ok) e_err = 1;
            end
            if (bus.rd_b_en) begin
                e_bv = 1;
                e_bd = b_ok ? W'(model[br * C + bc]) : '0;
                if (!b_ok) e_err = 1;
            end
        end
        @(posedge clk);
        if (busy_left > 0) busy_left--;
        else begin
            if (bus.wr_en && w_ok) model[wr * C + wc] = int'(bus.wr_data);
            if (bus.init_req) begin
                busy_left = N;
                load_init();
            end
        end
        #1;
        check_outputs();
    endtask
    task automatic do_reset(input int hold);
        rst = 1'b1;
        idle_inputs();
        busy_left = N;
        e_ack = 0; e_av = 0; e_bv = 0; e_err = 0; e_ad = '0; e_bd = '0;
        #1;
        check_outputs();
        repeat (hold) @(posedge clk);
        #1 rst = 1'b0;
        load_init();
    endtask
    initial begin
        idle_inputs();
        #2;
        do_reset(2);
        repeat (N + 1) cycle();
        for (int k = 0; k < N; k++) begin
            set_a(1, k / C, k % C);
            set_b(1, k / C, k % C, 0);
            cycle();
        end
        idle_inputs();
        cycle();
        set_wr(1, 1, 0, 8'hAA);
        cycle();
        set_wr(0, 0, 0, 0);
        set_a(1, 0, 0);
        set_b(1, 0, 1, 1);
        cycle();
        set_wr(1, 1, 1, 8'h3C);
        set_a(1, 1, 1);
        set_b(0, 0, 0, 0);
        cycle();
        set_wr(0, 0, 0, 0);
        cycle();
        set_wr(1, 3, 0, 8'h55);
        set_a(1, 3, 1);
        set_b(1, 2, 0, 1);
        cycle();
        set_wr(0, 0, 0, 0);
        set_a(0, 0, 0);
        set_b(1, 2, 1, 0);
        cycle();
        set_b(0, 0, 0, 0);
        bus.init_req = 1'b1;
        cycle();
        set_wr(1, 0, 0, 8'h11);
        set_a(1, 0, 0);
        set_b(1, 1, 1, 0);
        repeat (3) cycle();
        do_reset(1);
        repeat (N + 2) cycle();
        for (int n = 0; n < 3000; n++) begin
            set_wr(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
            set_a(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
            set_b(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
            bus.init_req = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 400) == 0) do_reset(int'($urandom_range(1, 3)));
            else cycle();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
